// File: rtl/k_sync_fifo_p.sv
// Single-clock synchronous FIFO, 2^ADDR_SIZE x DATA_SIZE, registered read data and level flags.
// Optional sticky overflow/underflow error flags when K_FIFO_ERR_FLAGS_EN is defined.
module k_sync_fifo_p #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned AFULL_TH  = (1 << ADDR_SIZE) - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [DATA_SIZE-1:0] d,
    input  logic                 ren,
    output logic [DATA_SIZE-1:0] q,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count
`ifdef K_FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    localparam int unsigned        DEPTH    = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE + 1)'(DEPTH);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_SIZE-1:0] r_wptr;
    logic [ADDR_SIZE-1:0] r_rptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [ADDR_SIZE:0]   w_count_d;
    logic [DATA_SIZE-1:0] r_q;
    logic                 w_wr_ok;
    logic                 w_rd_ok;

    // Acceptance uses only registered flags, so a write into a full FIFO is
    // rejected even when a read frees a slot in the same cycle.
    assign w_wr_ok = wen & ~full;
    assign w_rd_ok = ren & ~empty;

    always_comb begin
        w_count_d = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_d = r_count + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_d = r_count - 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_q     <= '0;
        end else begin
            r_count <= w_count_d;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
                r_q    <= r_mem[r_rptr];
            end
        end
    end

    assign q            = r_q;
    assign count        = r_count;
    assign full         = (r_count == FULL_CNT);
    assign empty        = (r_count == '0);
    assign almost_full  = (32'(r_count) >= AFULL_TH);
    assign almost_empty = (32'(r_count) <= AEMPTY_TH);

`ifdef K_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (wen & full);
            r_underflow <= r_underflow | (ren & empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_k_sync_fifo_p.sv
// Scoreboard bench for k_sync_fifo_p: stimulus queues expected read words, a monitor checks q.
// Error-flag checks are compiled in only when K_FIFO_ERR_FLAGS_EN is defined.
module tb_k_sync_fifo_p;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [7:0] d;
    logic       ren;
    logic [7:0] q;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
`ifdef K_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    logic       tb_rd_exp;
    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    k_sync_fifo_p #(
        .DATA_SIZE(8),
        .ADDR_SIZE(4),
        .AFULL_TH (14),
        .AEMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .d           (d),
        .ren         (ren),
        .q           (q),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count)
`ifdef K_FIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one cycle after an expected-accepted read, q must match the queue head.
    initial begin
        logic       hit;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            hit = tb_rd_exp & ~rst;
            #1;
            if (hit) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL q_unexpected: got 0x%0h, expected no read", q);
                end else begin
                    e = exp_q.pop_front();
                    if (q != e) begin
                        n_errors++;
                        $display("FAIL q_data: got 0x%0h, expected 0x%0h at %0t", q, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive at negedge, let one posedge pass, return at next negedge idle.
    task automatic cyc(input logic w, input logic [7:0] dv, input logic r,
                       input logic rexp, input logic [7:0] rval);
        wen       = w;
        d         = dv;
        ren       = r;
        tb_rd_exp = rexp;
        if (rexp) exp_q.push_back(rval);
        @(posedge clk);
        @(negedge clk);
        wen       = 1'b0;
        ren       = 1'b0;
        tb_rd_exp = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input int c);
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_full"}, int'(full), int'(c == 16));
        chk({tag, "_empty"}, int'(empty), int'(c == 0));
        chk({tag, "_afull"}, int'(almost_full), int'(c >= 14));
        chk({tag, "_aempty"}, int'(almost_empty), int'(c <= 2));
    endtask

    initial begin
        logic [7:0] wv;
        logic [7:0] rv;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        wen       = 1'b0;
        ren       = 1'b0;
        d         = '0;
        tb_rd_exp = 1'b0;
        repeat (2) @(negedge clk);
        chk_flags("reset", 0);
        chk("reset_q", int'(q), 0);
`ifdef K_FIFO_ERR_FLAGS_EN
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_udf", int'(underflow), 0);
`endif
        rst = 1'b0;

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            chk_flags("fill", i);
        end
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        chk_flags("wr_full", 16);
`ifdef K_FIFO_ERR_FLAGS_EN
        chk("overflow", int'(overflow), 1);
`endif

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
            chk_flags("drain", 16 - i);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("rd_empty_q", int'(q), 8'h10);
        chk_flags("rd_empty", 0);
`ifdef K_FIFO_ERR_FLAGS_EN
        chk("underflow", int'(underflow), 1);
`endif

        // Simultaneous on empty: write only, no bypass
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00);
        chk("wr_rd_empty_count", int'(count), 1);
        chk("wr_rd_empty_q", int'(q), 8'h10);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
        chk_flags("after_a5", 0);

        // Simultaneous on full: read only, 0x77 dropped
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00);
        chk_flags("refill", 16);
        cyc(1'b1, 8'h77, 1'b1, 1'b1, 8'h20);
        chk_flags("wr_rd_full", 15);
        for (int i = 1; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h20 + i));
        chk_flags("after_77", 0);

        // Half-full streaming across pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
        wv = 8'h48;
        rv = 8'h40;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, wv, 1'b1, 1'b1, rv);
            chk("stream_count", int'(count), 8);
            wv = wv + 8'd1;
            rv = rv + 8'd1;
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b1, rv);
            rv = rv + 8'd1;
        end
        chk_flags("stream_end", 0);

        // Asynchronous reset mid-stream at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 8'h00);
        chk_flags("pre_rst", 5);
        #2 rst = 1'b1;
        #1;
        chk_flags("async_rst", 0);
        chk("async_rst_q", int'(q), 0);
`ifdef K_FIFO_ERR_FLAGS_EN
        chk("async_rst_ovf", int'(overflow), 0);
        chk("async_rst_udf", int'(underflow), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00);
        chk_flags("post_rst_wr", 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'hC3);
        chk_flags("post_rst_rd", 0);

        @(negedge clk);
        chk("scoreboard_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
